// File: rtl/game_timer_if.sv
// Command and display bundle between the game top level and game_timer.
// master: top-level side (drives iMODE); slave: the timer itself.
interface game_timer_if;
  logic [1:0] iMODE;
  logic [6:0] oHEX0;
  logic [6:0] oHEX1;
  logic [6:0] oSEC;
  logic       oTICK;
  logic       oTIMEOUT;

  modport master (
    output iMODE,
    input  oHEX0, oHEX1, oSEC, oTICK, oTIMEOUT
  );

  modport slave (
    input  iMODE,
    output oHEX0, oHEX1, oSEC, oTICK, oTIMEOUT
  );
endinterface

// File: rtl/game_timer.sv
// Two-digit BCD countdown timer for the maze game, one decrement per CLK_HZ cycles.
// Optional GAME_TIMER_BLINK_EN: blink the HEX digits while expired.
module game_timer #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int START_SEC = 60
) (
  input  logic        iCLK,
  input  logic        iRST,
  game_timer_if.slave bus
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_MAX    = PW'(CLK_HZ - 1);
  localparam logic [3:0]    START_TENS = 4'(START_SEC / 10);
  localparam logic [3:0]    START_ONES = 4'(START_SEC % 10);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PAUSED  = 2'd1,
    ST_FROZEN  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CMD_RUN    = 2'b00,
    CMD_PAUSE  = 2'b01,
    CMD_RELOAD = 2'b10,
    CMD_FREEZE = 2'b11
  } cmd_t;

  state_t          state, state_n;
  logic [PW-1:0]   pre, pre_n;
  logic [3:0]      tens, tens_n;
  logic [3:0]      ones, ones_n;
  logic            tick, tick_n;
  logic            timeout, timeout_n;
  logic            blank;
  cmd_t            cmd;

  assign cmd = cmd_t'(bus.iMODE);

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state   <= ST_RUN;
      pre     <= '0;
      tens    <= START_TENS;
      ones    <= START_ONES;
      tick    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      pre     <= pre_n;
      tens    <= tens_n;
      ones    <= ones_n;
      tick    <= tick_n;
      timeout <= timeout_n;
    end
  end

  always_comb begin
    state_n   = state;
    pre_n     = pre;
    tens_n    = tens;
    ones_n    = ones;
    tick_n    = 1'b0;
    timeout_n = timeout;

    if (cmd == CMD_RELOAD) begin
      state_n   = ST_RUN;
      pre_n     = '0;
      tens_n    = START_TENS;
      ones_n    = START_ONES;
      timeout_n = 1'b0;
    end else begin
      case (state)
        ST_RUN, ST_PAUSED: begin
          if (cmd == CMD_FREEZE) begin
            state_n = ST_FROZEN;
          end else if (cmd == CMD_PAUSE) begin
            state_n = ST_PAUSED;
          end else begin
            // Resuming from pause counts on the same edge, continuing the held phase.
            state_n = ST_RUN;
            if (pre != PRE_MAX) begin
              pre_n = pre + 1'b1;
            end else begin
              pre_n = '0;
              if ((tens != 4'd0) || (ones != 4'd0)) begin
                tick_n = 1'b1;
                if (ones == 4'd0) begin
                  ones_n = 4'd9;
                  tens_n = tens - 4'd1;
                end else begin
                  ones_n = ones - 4'd1;
                end
                if ((tens == 4'd0) && (ones == 4'd1)) begin
                  state_n   = ST_EXPIRED;
                  timeout_n = 1'b1;
                end
              end
            end
          end
        end
        ST_FROZEN: begin
        end
        ST_EXPIRED: begin
`ifdef GAME_TIMER_BLINK_EN
          pre_n = (pre == PRE_MAX) ? '0 : pre + 1'b1;
`else
          pre_n = '0;
`endif
        end
        default: state_n = ST_RUN;
      endcase
    end
  end

`ifdef GAME_TIMER_BLINK_EN
  localparam logic [PW-1:0] HALF = PW'(CLK_HZ / 2);
  assign blank = (state == ST_EXPIRED) && (pre >= HALF);
`else
  assign blank = 1'b0;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign bus.oHEX0    = blank ? 7'b1111111 : seg7(ones);
  assign bus.oHEX1    = blank ? 7'b1111111 : seg7(tens);
  assign bus.oSEC     = 7'(tens) * 7'd10 + 7'(ones);
  assign bus.oTICK    = tick;
  assign bus.oTIMEOUT = timeout;

endmodule

// File: tb/tb_game_timer.sv
// Scoreboard bench for game_timer: an integer-seconds reference model predicts each cycle's outputs.
module tb_game_timer;

  localparam int CLK_HZ    = 4;
  localparam int START_SEC = 12;
`ifdef GAME_TIMER_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  typedef struct {
    logic       tick;
    logic [6:0] sec;
    logic       timeout;
    logic [6:0] hex1;
    logic [6:0] hex0;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  game_timer_if bus ();

  game_timer #(.CLK_HZ(CLK_HZ), .START_SEC(START_SEC)) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // Reference model: seconds remaining and cycles elapsed within the current second.
  int secs    = START_SEC;
  int phase   = 0;
  bit frozen  = 1'b0;
  bit expired = 1'b0;
  bit tick_m  = 1'b0;

  function automatic logic [6:0] digit_segs(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic model_step(input logic r, input logic [1:0] m);
    tick_m = 1'b0;
    if (r || m == 2'b10) begin
      secs = START_SEC; phase = 0; frozen = 1'b0; expired = 1'b0;
    end else if (expired) begin
      if (BLINK) phase = (phase + 1) % CLK_HZ;
      else       phase = 0;
    end else if (frozen) begin
      // nothing moves until reload or reset
    end else if (m == 2'b11) begin
      frozen = 1'b1;
    end else if (m == 2'b00) begin
      phase = phase + 1;
      if (phase == CLK_HZ) begin
        phase  = 0;
        secs   = secs - 1;
        tick_m = 1'b1;
        if (secs == 0) expired = 1'b1;
      end
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] m);
    exp_t e;
    @(negedge clk);
    rst = r;
    bus.iMODE = m;
    model_step(r, m);
    e.tick    = tick_m;
    e.sec     = 7'(secs);
    e.timeout = expired;
    if (expired && BLINK && phase >= CLK_HZ / 2) begin
      e.hex1 = 7'b1111111;
      e.hex0 = 7'b1111111;
    end else begin
      e.hex1 = digit_segs(secs / 10);
      e.hex0 = digit_segs(secs % 10);
    end
    sb.push_back(e);
  endtask

  task automatic run_until_secs(input int target);
    for (int i = 0; i < 1000 && secs != target; i++) drive(1'b0, 2'b00);
  endtask

  task automatic run_until_phase(input int target);
    for (int i = 0; i < 100 && phase != target; i++) drive(1'b0, 2'b00);
  endtask

  // Monitor: compares every cycle's DUT outputs with the oldest prediction.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        tests++;
        if (bus.oTICK !== e.tick || bus.oSEC !== e.sec || bus.oTIMEOUT !== e.timeout ||
            bus.oHEX1 !== e.hex1 || bus.oHEX0 !== e.hex0) begin
          fails++;
          $display("FAIL outputs cyc=%0d tick/sec/timeout/hex1/hex0 got %b/%0d/%b/%b/%b expected %b/%0d/%b/%b/%b",
                   cyc, bus.oTICK, bus.oSEC, bus.oTIMEOUT, bus.oHEX1, bus.oHEX0,
                   e.tick, e.sec, e.timeout, e.hex1, e.hex0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d predictions pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    bus.iMODE = 2'b00;

    drive(1'b1, 2'b00);
    drive(1'b1, 2'b10);

    // Full countdown to expiry, then commands that must be ignored
    for (int i = 0; i < 48; i++) drive(1'b0, 2'b00);
    for (int i = 0; i < 10; i++) drive(1'b0, 2'($urandom_range(0, 1) == 0 ? 0 : 3));
    for (int i = 0; i < 6; i++)  drive(1'b0, 2'b01);

    // Freeze at 7, ignore run, reload, tick 4 cycles after release
    drive(1'b0, 2'b10);
    run_until_secs(7);
    drive(1'b0, 2'b11);
    for (int i = 0; i < 20; i++) drive(1'b0, 2'b00);
    drive(1'b0, 2'b10);
    for (int i = 0; i < 8; i++) drive(1'b0, 2'b00);

    // Pause with prescaler at 2, resume
    run_until_phase(2);
    for (int i = 0; i < 10; i++) drive(1'b0, 2'b01);
    for (int i = 0; i < 6; i++) drive(1'b0, 2'b00);

    // Freeze on the terminal-count cycle
    run_until_phase(CLK_HZ - 1);
    drive(1'b0, 2'b11);
    for (int i = 0; i < 6; i++) drive(1'b0, 2'b00);
    drive(1'b0, 2'b10);

    // Reset mid-count discards the prescaler phase
    drive(1'b0, 2'b00);
    drive(1'b0, 2'b00);
    drive(1'b1, 2'($urandom_range(0, 3)));
    for (int i = 0; i < 6; i++) drive(1'b0, 2'b00);

    // Expired with blink (if built in), then reload
    run_until_secs(0);
    for (int i = 0; i < 9; i++) drive(1'b0, 2'b00);
    drive(1'b0, 2'b10);

    // Randomized mix, mostly running so expiry is regularly reached
    for (int blk = 0; blk < 30; blk++) begin
      int run_w;
      run_w = (blk % 3 == 0) ? 99 : 85;
      for (int i = 0; i < 100; i++) begin
        int r;
        logic [1:0] m;
        r = $urandom_range(0, 999);
        if      (r < run_w * 10)        m = 2'b00;
        else if (r < run_w * 10 + 60)   m = 2'b01;
        else if (r < run_w * 10 + 100)  m = 2'b11;
        else                            m = 2'b10;
        drive(($urandom_range(0, 999) < 3) ? 1'b1 : 1'b0, m);
      end
    end

    @(posedge clk);
    #3;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
